// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM states, frame timing, line levels, baud divisors.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    // Start + 8 data + stop + one idle mark bit between frames.
    localparam int FRAME_TICKS_DEF = 11;

    localparam logic MARK_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int CLK_HZ = 27_000_000;

    function automatic int baud_divisor(input int baud);
        return (CLK_HZ + baud / 2) / baud;
    endfunction

    localparam int DIVISOR_9600   = baud_divisor(9600);
    localparam int DIVISOR_19200  = baud_divisor(19200);
    localparam int DIVISOR_57600  = baud_divisor(57600);
    localparam int DIVISOR_115200 = baud_divisor(115200);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester picker: first valid index at/after ptr (wrapping), or lowest index with UART_ARB_FIXED_PRIO_EN.
// Latency: zero cycles, purely combinational.
// Backpressure: none; grant is only a selection, the caller decides when it is consumed.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [IDX_W-1:0] cand;

`ifdef UART_ARB_FIXED_PRIO_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'(k);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = grant_vld;
    end
`else
    localparam logic [IDX_W:0] NREQ_EXT = (IDX_W+1)'(NREQ);

    logic [IDX_W:0] sum;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Modular add without a divider: both operands are below NREQ.
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= NREQ_EXT) begin
                sum = sum - NREQ_EXT;
            end
            cand = sum[IDX_W-1:0];
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = grant_vld;
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 transmitter among NREQ byte producers; round-robin, or fixed priority with UART_ARB_FIXED_PRIO_EN.
// Latency: req_ready same cycle as a valid request when idle, tx_send the next cycle; send spacing FRAME_TICKS ticks + 2 clocks.
// Backpressure: req_ready withheld while a frame is in flight; the frame is timed by counting tx_xmit_clk ticks.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                tx_xmit_clk,
    output logic [7:0]          tx_data,
    output logic                tx_send,
    output logic                busy,
    output logic [IDX_W-1:0]    grant_id,
    output logic [CNT_W-1:0]    frames_sent
);

    localparam int TCNT_W = $clog2(FRAME_TICKS + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_ptr_nxt;
    logic [TCNT_W-1:0] tick_cnt;
    logic              frame_done;
    logic              accept;

    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;
    logic [7:0]        req_bytes [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign accept     = (state == IDLE) && arb_vld;
    assign frame_done = (state == WAIT) && tx_xmit_clk
                        && (tick_cnt == TCNT_W'(FRAME_TICKS - 1));

`ifdef UART_ARB_FIXED_PRIO_EN
    assign rr_ptr_nxt = '0;
`else
    assign rr_ptr_nxt = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld)    state_nxt = SEND;
            SEND:                    state_nxt = WAIT;
            WAIT:    if (frame_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Masked during reset so no requester drops a byte that will never be sent.
    assign req_ready = (accept && !reset) ? arb_grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_send     <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= '0;
            rr_ptr      <= '0;
            tick_cnt    <= '0;
            frames_sent <= '0;
        end else begin
            tx_send <= accept;
            if (accept) begin
                tx_data  <= req_bytes[arb_idx];
                grant_id <= arb_idx;
                rr_ptr   <= rr_ptr_nxt;
            end
            // A tick landing on the SEND cycle is dropped by the clear.
            if (state == SEND) begin
                frames_sent <= frames_sent + 1'b1;
                tick_cnt    <= '0;
            end else if (state == WAIT && tx_xmit_clk) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    a_send_isolated: assert property (@(posedge clk) disable iff (reset)
        tx_send |=> !tx_send);
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));
    a_tick_bound: assert property (@(posedge clk) disable iff (reset)
        tick_cnt <= TCNT_W'(FRAME_TICKS));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level model; honours UART_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int FT   = 11;
    localparam int CW   = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_xmit_clk;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [CW-1:0]     frames_sent;

    uart_tx_arbiter #(.NREQ(NREQ), .FRAME_TICKS(FT), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_xmit_clk (tx_xmit_clk),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .busy        (busy),
        .grant_id    (grant_id),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Producer byte queues; the head is what the requester presents.
    logic [7:0] q [NREQ][$];

    // Reference model: arbiter is either free, issuing a send, or waiting out m_left ticks.
    bit         m_idle, m_send;
    int         m_left, m_ptr, m_grant, m_total;
    logic [7:0] m_data;

    int  p_valid, p_tick, cyc, last_send;
    bit  force_tick_on_send, gap_chk, feed, prev_send;
    int  glist[$];
    int  dlist[$];
    int  tq[$];
    int  exp_g[5];
    int  exp_d[5];
    int  exp_fp[3];

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        int c;
        for (int k = 0; k < NREQ; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            c = k + 0 * ptr;
`else
            c = (ptr + k) % NREQ;
`endif
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit q_empty();
        for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_send = 1'b0; m_left = 0; m_ptr = 0;
        m_grant = 0; m_total = 0; m_data = 8'h00;
        prev_send = 1'b0; last_send = -1;
        tq.delete();
    endtask

    task automatic cycle(input bit rel = 1'b0);
        logic [NREQ-1:0]   v;
        logic [7:0]        b [NREQ];
        logic [8*NREQ-1:0] pd;
        logic [NREQ-1:0]   er;
        int w, n, lt, r;
        @(posedge clk); #1;
        if (rel) reset = 1'b0;
        cyc++;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            b[i] = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
            if (q[i].size() > 0 && int'($urandom_range(99)) < p_valid) v[i] = 1'b1;
            pd[8*i +: 8] = b[i];
        end
        req_valid   = v;
        req_data    = pd;
        tx_xmit_clk = (force_tick_on_send && m_send) ? 1'b1 : (int'($urandom_range(99)) < p_tick);
        @(negedge clk);
        w  = (!reset && m_idle) ? pick(v, m_ptr) : -1;
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        check_eq("tx_send", tx_send, m_send);
        check_eq("busy", busy, !m_idle);
        check_eq("tx_data", tx_data, m_data);
        check_eq("grant_id", grant_id, m_grant);
        check_eq("frames_sent", frames_sent, m_total % (1 << CW));
        check_eq("req_ready", req_ready, er);
        check_eq("no_adjacent_send", tx_send & prev_send, 0);
        prev_send = tx_send;
        if (tx_xmit_clk) tq.push_back(cyc);
        if (tx_send === 1'b1) begin
            glist.push_back(int'(grant_id));
            dlist.push_back(int'(tx_data));
            if (gap_chk && last_send >= 0) begin
                n = 0; lt = -1;
                foreach (tq[k]) if (tq[k] > last_send && tq[k] <= cyc - 2) begin n++; lt = tq[k]; end
                check_eq("gap_ticks", n, FT);
                check_eq("gap_last_tick", lt, cyc - 2);
            end
            last_send = cyc;
            tq.delete();
        end
        if (!reset) begin
            if (m_idle) begin
                if (w >= 0) begin
                    m_data = b[w]; m_grant = w; m_idle = 1'b0; m_send = 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
                    m_ptr = 0;
`else
                    m_ptr = (w + 1) % NREQ;
`endif
                    void'(q[w].pop_front());
                end
            end else if (m_send) begin
                m_send = 1'b0; m_total++; m_left = FT;
            end else if (tx_xmit_clk) begin
                m_left--;
                if (m_left == 0) m_idle = 1'b1;
            end
        end
        if (feed && $urandom_range(3) == 0) begin
            r = $urandom_range(NREQ - 1);
            if (q[r].size() < 3) q[r].push_back(8'($urandom));
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(m_idle && q_empty()) && n < budget) begin cycle(); n++; end
        check_eq("drain_done", m_idle && q_empty(), 1);
    endtask

    // Called just after a falling edge, so the reset edge lands mid-cycle.
    task automatic assert_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_send", tx_send, 0);
        check_eq("rst_frames", frames_sent, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_grant_id", grant_id, 0);
        model_reset();
    endtask

    task automatic release_reset();
        cycle();
        cycle(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 1, 2, 3}; exp_d = '{'h10, 'h54, 'h21, 'h32, 'h43}; exp_fp = '{0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0}; exp_d = '{'h10, 'h21, 'h32, 'h43, 'h54}; exp_fp = '{0, 2, 0};
`endif
        reset = 1'b1; req_valid = '0; req_data = '0; tx_xmit_clk = 1'b0;
        p_valid = 100; p_tick = 50; cyc = 0;
        force_tick_on_send = 1'b0; gap_chk = 1'b0; feed = 1'b0;
        model_reset();
        #2;
        check_eq("init_busy", busy, 0);
        check_eq("init_frames", frames_sent, 0);
        check_eq("init_req_ready", req_ready, 0);
        release_reset();

        // Single byte from requester 0.
        glist.delete(); dlist.delete();
        q[0].push_back(8'h41);
        drain(400);
        check_eq("single_count", glist.size(), 1);
        check_eq("single_grant", glist.size() > 0 ? glist[0] : -1, 0);
        check_eq("single_data", dlist.size() > 0 ? dlist[0] : -1, 'h41);
        check_eq("single_frames", frames_sent, 1);

        // All four valid, back to back, with a tick forced onto every SEND cycle.
        assert_reset(); release_reset();
        glist.delete(); dlist.delete();
        q[0].push_back(8'h10); q[0].push_back(8'h54);
        q[1].push_back(8'h21); q[2].push_back(8'h32); q[3].push_back(8'h43);
        gap_chk = 1'b1; force_tick_on_send = 1'b1; p_tick = 60;
        drain(1000);
        gap_chk = 1'b0; force_tick_on_send = 1'b0;
        check_eq("order_count", glist.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("order_grant%0d", i), i < glist.size() ? glist[i] : -1, exp_g[i]);
            check_eq($sformatf("order_data%0d", i), i < dlist.size() ? dlist[i] : -1, exp_d[i]);
        end

        // Requesters 0 and 2 held valid.
        assert_reset(); release_reset();
        glist.delete(); dlist.delete();
        for (int i = 0; i < 3; i++) begin q[0].push_back(8'($urandom)); q[2].push_back(8'($urandom)); end
        for (int n = 0; n < 1000 && glist.size() < 3; n++) cycle();
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("prio_grant%0d", i), i < glist.size() ? glist[i] : -1, exp_fp[i]);
        drain(1000);

        // Reset five ticks into WAIT, then a fresh request.
        assert_reset(); release_reset();
        q[1].push_back(8'h77); q[2].push_back(8'h78); p_tick = 50;
        for (int n = 0; n < 500 && !(!m_idle && !m_send && m_left == FT - 5); n++) cycle();
        check_eq("reached_wait5", !m_idle && !m_send && m_left == FT - 5, 1);
        assert_reset();
        for (int i = 0; i < NREQ; i++) q[i].delete();
        q[3].push_back(8'h5A);
        release_reset();
        dlist.delete();
        drain(400);
        check_eq("post_rst_data", dlist.size() > 0 ? dlist[dlist.size()-1] : -1, 'h5A);
        check_eq("post_rst_frames", frames_sent, 1);

        // Random traffic through the counter wrap.
        assert_reset(); release_reset();
        feed = 1'b1; p_valid = 70;
        for (int n = 0; n < 4000 && m_total < 17; n++) begin
            if (n % 50 == 0) p_tick = (n % 200 == 0) ? 100 : int'($urandom_range(20, 90));
            cycle();
        end
        cycle();
        check_eq("wrap_total", m_total, 17);
        check_eq("frames_wrap", frames_sent, 1);
        for (int n = 0; n < 600; n++) cycle();
        feed = 1'b0;
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 serial transmitter between NREQ byte-producing requesters.
- Round-robin arbitration among valid requesters.
- Drives the transmitter's edge-triggered send input and data byte.
- Times each frame by counting the transmitter's baud-tick output, so the transmitter is never re-triggered mid-frame.
- Sits between the capture/telemetry producers and the RS-232 transmitter on the 27 MHz clock domain.

Parameters:
- NREQ, 4: number of requesters (2..8).
- FRAME_TICKS, 11: baud ticks waited after a send before the next send. Covers start bit, 8 data bits, stop bit and one mark bit.
- CNT_W, 16: width of the frames_sent counter.

Ports:
- clk  input  1  system clock (27 MHz).
- reset  input  1  asynchronous, active-high reset. Also tied to the transmitter's reset.
- req_valid  input  NREQ  per-requester byte-valid.
- req_data  input  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_ready  output  NREQ  one-cycle accept pulse, one-hot.
- tx_xmit_clk  input  1  baud tick from the transmitter, one-cycle pulse.
- tx_data  output  8  byte to the transmitter, registered.
- tx_send  output  1  send pulse to the transmitter, one cycle high.
- busy  output  1  high while a frame is being sent or awaited.
- grant_id  output  $clog2(NREQ)  index of the last granted requester.
- frames_sent  output  CNT_W  total bytes handed to the transmitter; wraps.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, tx_send=0, tx_data=8'h00, req_ready=0, busy=0.
  - grant_id=0, rr pointer=0, tick count=0, frames_sent=0.
- States: IDLE, SEND, WAIT.
- IDLE:
  - If any req_valid is high, pick the winner: the first valid index at or after the rr pointer, searching upward with wrap.
  - Register tx_data=req_data[winner] and grant_id=winner.
  - Pulse req_ready[winner] in this cycle (combinational from the arbiter, gated by state==IDLE).
  - Set rr pointer = winner+1 mod NREQ and go to SEND.
  - If no req_valid is high, stay in IDLE.
- SEND:
  - tx_send=1 for exactly this cycle; tx_data is stable.
  - frames_sent increments; tick count clears; go to WAIT.
- WAIT:
  - Count tx_xmit_clk pulses; a tick coinciding with the SEND cycle is not counted.
  - When the count reaches FRAME_TICKS, return to IDLE.
  - An arbitration for the next byte can therefore occur in that same IDLE cycle.
- busy=1 in SEND and WAIT, 0 in IDLE.
- Latency:
  - Valid request with the arbiter idle: req_ready in the same cycle, tx_send on the next cycle.
  - Back-to-back bytes: send-to-send spacing is FRAME_TICKS ticks plus 2 clocks.
- tx_send is never high on two consecutive cycles, so the transmitter sees a clean rising edge for every byte.
- Requesters must hold req_data stable while req_valid is high. They drop or advance the byte on the cycle after req_ready.
- req_valid deasserted before grant: no effect, no frame sent.
- A single requester continuously valid is granted every frame; the pointer wraps past it and returns to it.
- Reset mid-WAIT: return to IDLE at once; the in-flight frame is aborted (the transmitter line goes to mark). frames_sent clears.
- tx_xmit_clk in IDLE: ignored.
- frames_sent wraps from 2^CNT_W-1 to 0.

Optional Feature:
- UART_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest valid index always wins, and the rr pointer is unused and held at 0.
- Undefined (default): round-robin as described above.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, SEND, WAIT);
  - FRAME_TICKS default;
  - MARK/START/STOP bit constants;
  - baud DIVISOR constants for 27 MHz.
- One sub-module, rr_arbiter: combinational. Takes req vector and pointer; returns a one-hot grant and an encoded index. Honours UART_ARB_FIXED_PRIO_EN.

Test Plan:
- Single byte: req_valid=4'b0001, req_data[7:0]=8'h41 → req_ready[0] pulses once; tx_send pulses next cycle with tx_data=8'h41. busy stays high for 11 ticks; frames_sent=1.
- All four valid continuously, bytes 8'h10/8'h21/8'h32/8'h43 → grant order 0,1,2,3,0. tx_send pulses are spaced by 11 ticks plus 2 clocks, never adjacent.
- Fixed priority (UART_ARB_FIXED_PRIO_EN) with req 0 and 2 held valid → only requester 0 is granted for 3 frames.
- Tick coincident with the SEND cycle (tx_xmit_clk forced high on that cycle) → still 11 further ticks counted before returning to IDLE.
- Reset asserted 5 ticks into WAIT → asynchronous return to IDLE; busy=0, frames_sent=0, tx_send=0. After release, a fresh request is served normally.
- CNT_W=4 with 17 frames sent → frames_sent wraps to 1.
